// File: rtl/mips_multicycle_control.sv
// mips_multicycle_control: multi-cycle main control FSM for the load/store and R/I-type datapath,
// with illegal-instruction reporting and a retired-instruction counter.
module mips_multicycle_control #(
    parameter int COUNT_W = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [31:0]        instruction,
    input  logic               zero_flag,
    input  logic               mem_ready,
    output logic               IRWrite,
    output logic               PCWrite,
    output logic               PCWriteCond,
    output logic               RegWrite,
    output logic               MemRead,
    output logic               MemWrite,
    output logic               MemtoReg,
    output logic               ALUSrc,
    output logic               RegDst,
    output logic [3:0]         ALU_OP,
    output logic               instr_done,
    output logic               illegal,
    output logic               branch_taken,
    output logic [3:0]         state,
    output logic [COUNT_W-1:0] instr_count
);
    typedef enum logic [3:0] {
        FETCH, DECODE, MEM_ADDR, MEM_READ, MEM_WB, MEM_WRITE,
        R_EXEC, R_WB, I_EXEC, I_WB, BRANCH
    } state_t;

    state_t     cur, nxt;
    logic [5:0] op_q, funct_q;
    logic [5:0] op, funct;
    logic       is_mem, is_r, is_i, is_beq, funct_ok;
    logic [3:0] alu_r, alu_i;
    logic       unused_bits;

    assign op          = instruction[31:26];
    assign funct       = instruction[5:0];
    assign unused_bits = ^instruction[25:6];
    assign is_mem      = op == 6'b100011 || op == 6'b101011;
    assign is_r        = op == 6'b000000;
    assign is_i        = op == 6'b001000 || op == 6'b001100 || op == 6'b001101;
    assign is_beq      = op == 6'b000100;
    assign funct_ok    = funct == 6'b100000 || funct == 6'b100010 || funct == 6'b100100 ||
                         funct == 6'b100101 || funct == 6'b101010;
    assign alu_r = funct_q == 6'b100000 ? 4'b0010 :
                   funct_q == 6'b100010 ? 4'b0110 :
                   funct_q == 6'b100100 ? 4'b0000 :
                   funct_q == 6'b100101 ? 4'b0001 : 4'b0111;
    assign alu_i = op_q == 6'b001100 ? 4'b0000 :
                   op_q == 6'b001101 ? 4'b0001 : 4'b0010;
    assign state        = cur;
    assign branch_taken = PCWriteCond & zero_flag;

    always_ff @(posedge clk) begin
        if (rst) begin
            cur         <= FETCH;
            op_q        <= '0;
            funct_q     <= '0;
            illegal     <= 1'b0;
            instr_count <= '0;
        end else begin
            cur         <= nxt;
            illegal     <= cur == DECODE && nxt == FETCH;
            instr_count <= instr_count + COUNT_W'(instr_done);
            if (cur == DECODE) begin
                op_q    <= op;
                funct_q <= funct;
            end
        end
    end

    always_comb begin
        nxt         = cur;
        IRWrite     = 1'b0;
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        RegWrite    = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        MemtoReg    = 1'b0;
        ALUSrc      = 1'b0;
        RegDst      = 1'b0;
        ALU_OP      = 4'b0010;
        instr_done  = 1'b0;
        case (cur)
            FETCH: begin
                IRWrite = 1'b1;
                PCWrite = 1'b1;
                nxt     = DECODE;
            end
            DECODE: nxt = is_mem ? MEM_ADDR :
                          (is_r && funct_ok) ? R_EXEC :
                          is_i ? I_EXEC :
                          is_beq ? BRANCH : FETCH;
            MEM_ADDR: begin
                ALUSrc = 1'b1;
                nxt    = op_q == 6'b100011 ? MEM_READ : MEM_WRITE;
            end
            MEM_READ: begin
                ALUSrc  = 1'b1;
                MemRead = 1'b1;
                nxt     = mem_ready ? MEM_WB : MEM_READ;
            end
            MEM_WB: begin
                ALUSrc     = 1'b1;
                MemRead    = 1'b1;
                MemtoReg   = 1'b1;
                RegWrite   = 1'b1;
                instr_done = 1'b1;
                nxt        = FETCH;
            end
            MEM_WRITE: begin
                ALUSrc     = 1'b1;
                MemWrite   = 1'b1;
                instr_done = mem_ready;
                nxt        = mem_ready ? FETCH : MEM_WRITE;
            end
            R_EXEC: begin
                ALU_OP = alu_r;
                nxt    = R_WB;
            end
            R_WB: begin
                ALU_OP     = alu_r;
                RegDst     = 1'b1;
                RegWrite   = 1'b1;
                instr_done = 1'b1;
                nxt        = FETCH;
            end
            I_EXEC: begin
                ALUSrc = 1'b1;
                ALU_OP = alu_i;
                nxt    = I_WB;
            end
            I_WB: begin
                ALUSrc     = 1'b1;
                ALU_OP     = alu_i;
                RegWrite   = 1'b1;
                instr_done = 1'b1;
                nxt        = FETCH;
            end
            BRANCH: begin
                ALU_OP      = 4'b0110;
                PCWriteCond = 1'b1;
                instr_done  = 1'b1;
                nxt         = FETCH;
            end
            default: nxt = FETCH;
        endcase
        // reset overrides every control output so nothing is written while aborting
        if (rst) begin
            IRWrite     = 1'b0;
            PCWrite     = 1'b0;
            PCWriteCond = 1'b0;
            RegWrite    = 1'b0;
            MemRead     = 1'b0;
            MemWrite    = 1'b0;
            MemtoReg    = 1'b0;
            ALUSrc      = 1'b0;
            RegDst      = 1'b0;
            ALU_OP      = 4'b0010;
            instr_done  = 1'b0;
        end
    end
endmodule

// File: tb/tb_mips_multicycle_control.sv
// tb_mips_multicycle_control: directed per-cycle checks of state, control outputs and counters.
module tb_mips_multicycle_control;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] instruction = '0;
    logic        zero_flag = 1'b0;
    logic        mem_ready = 1'b1;
    logic        IRWrite, PCWrite, PCWriteCond, RegWrite, MemRead, MemWrite;
    logic        MemtoReg, ALUSrc, RegDst, instr_done, illegal, branch_taken;
    logic [3:0]  ALU_OP, state;
    logic [31:0] instr_count;
    int          total = 0;
    int          passed = 0;

    mips_multicycle_control #(.COUNT_W(32)) dut (
        .clk(clk), .rst(rst), .instruction(instruction), .zero_flag(zero_flag),
        .mem_ready(mem_ready), .IRWrite(IRWrite), .PCWrite(PCWrite),
        .PCWriteCond(PCWriteCond), .RegWrite(RegWrite), .MemRead(MemRead),
        .MemWrite(MemWrite), .MemtoReg(MemtoReg), .ALUSrc(ALUSrc), .RegDst(RegDst),
        .ALU_OP(ALU_OP), .instr_done(instr_done), .illegal(illegal),
        .branch_taken(branch_taken), .state(state), .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    // {IR,PC,PCC,RW,MR,MW,M2R,AS,RD,done,bt,ALU_OP}
    function automatic logic [14:0] ctl();
        return {IRWrite, PCWrite, PCWriteCond, RegWrite, MemRead, MemWrite, MemtoReg,
                ALUSrc, RegDst, instr_done, branch_taken, ALU_OP};
    endfunction

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (ctl() !== 15'b00000000000_0010) $display("FAIL reset_ctl got %b exp %b", ctl(), 15'b00000000000_0010);
        else passed++;
        total++;
        if (state !== 4'd0 || instr_count !== 32'd0 || illegal !== 1'b0)
            $display("FAIL reset_state got st=%0d cnt=%0d ill=%b exp 0 0 0", state, instr_count, illegal);
        else passed++;
        rst = 1'b0;
    endtask

    task automatic test_lw(input logic [31:0] exp_cnt);
        logic [3:0]  es [5] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4};
        logic [14:0] ec [5] = '{15'b11000000000_0010, 15'b00000000000_0010, 15'b00000001000_0010,
                                15'b00001001000_0010, 15'b00011011010_0010};
        instruction = 32'h8C410001;
        for (int i = 0; i < 5; i++) begin
            mem_ready = 1'b1;
            #1;
            total++;
            if (state !== es[i] || ctl() !== ec[i])
                $display("FAIL lw[%0d] got st=%0d ctl=%b exp st=%0d ctl=%b", i, state, ctl(), es[i], ec[i]);
            else passed++;
            @(posedge clk); #1;
        end
        total++;
        if (state !== 4'd0 || instr_count !== exp_cnt)
            $display("FAIL lw_end got st=%0d cnt=%0d exp st=0 cnt=%0d", state, instr_count, exp_cnt);
        else passed++;
    endtask

    task automatic test_sw_wait();
        logic [3:0]  es [7] = '{4'd0, 4'd1, 4'd2, 4'd5, 4'd5, 4'd5, 4'd5};
        logic        mr [7] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        logic [14:0] ec [7] = '{15'b11000000000_0010, 15'b00000000000_0010, 15'b00000001000_0010,
                                15'b00000101000_0010, 15'b00000101000_0010, 15'b00000101000_0010,
                                15'b00000101010_0010};
        instruction = 32'hACA50002;
        for (int i = 0; i < 7; i++) begin
            mem_ready = mr[i];
            #1;
            total++;
            if (state !== es[i] || ctl() !== ec[i])
                $display("FAIL sw[%0d] got st=%0d ctl=%b exp st=%0d ctl=%b", i, state, ctl(), es[i], ec[i]);
            else passed++;
            @(posedge clk); #1;
        end
        mem_ready = 1'b1;
        total++;
        if (state !== 4'd0 || instr_count !== 32'd2)
            $display("FAIL sw_end got st=%0d cnt=%0d exp st=0 cnt=2", state, instr_count);
        else passed++;
    endtask

    task automatic test_rtype();
        logic [31:0] in [8] = '{32'h00018020, 32'h00018020, 32'hFFFFFFFF, 32'hFFFFFFFF,
                                32'h0128A822, 32'h0128A822, 32'hFFFFFFFF, 32'hFFFFFFFF};
        logic [3:0]  es [8] = '{4'd0, 4'd1, 4'd6, 4'd7, 4'd0, 4'd1, 4'd6, 4'd7};
        logic [14:0] ec [8] = '{15'b11000000000_0010, 15'b00000000000_0010, 15'b00000000000_0010,
                                15'b00010000110_0010, 15'b11000000000_0010, 15'b00000000000_0010,
                                15'b00000000000_0110, 15'b00010000110_0110};
        for (int i = 0; i < 8; i++) begin
            instruction = in[i];
            #1;
            total++;
            if (state !== es[i] || ctl() !== ec[i])
                $display("FAIL rtype[%0d] got st=%0d ctl=%b exp st=%0d ctl=%b", i, state, ctl(), es[i], ec[i]);
            else passed++;
            @(posedge clk); #1;
        end
        total++;
        if (state !== 4'd0 || instr_count !== 32'd4)
            $display("FAIL rtype_end got st=%0d cnt=%0d exp st=0 cnt=4", state, instr_count);
        else passed++;
    endtask

    task automatic test_andi_beq();
        logic [31:0] in [7] = '{32'h30D60000, 32'h30D60000, 32'h30D60000, 32'h30D60000,
                                32'h10000003, 32'h10000003, 32'h10000003};
        logic [3:0]  es [7] = '{4'd0, 4'd1, 4'd8, 4'd9, 4'd0, 4'd1, 4'd10};
        logic [14:0] ec [7] = '{15'b11000000000_0010, 15'b00000000000_0010, 15'b00000001000_0000,
                                15'b00010001010_0000, 15'b11000000000_0010, 15'b00000000000_0010,
                                15'b00100000011_0110};
        zero_flag = 1'b1;
        for (int i = 0; i < 7; i++) begin
            instruction = in[i];
            #1;
            total++;
            if (state !== es[i] || ctl() !== ec[i])
                $display("FAIL andi_beq[%0d] got st=%0d ctl=%b exp st=%0d ctl=%b", i, state, ctl(), es[i], ec[i]);
            else passed++;
            @(posedge clk); #1;
        end
        zero_flag = 1'b0;
        total++;
        if (state !== 4'd0 || instr_count !== 32'd6)
            $display("FAIL andi_beq_end got st=%0d cnt=%0d exp st=0 cnt=6", state, instr_count);
        else passed++;
    endtask

    task automatic test_illegal();
        logic [31:0] in [4] = '{32'hFC000000, 32'hFC000000, 32'h0000003F, 32'h0000003F};
        logic [3:0]  es [4] = '{4'd0, 4'd1, 4'd0, 4'd1};
        logic        ei [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 4; i++) begin
            instruction = in[i];
            #1;
            total++;
            if (state !== es[i] || illegal !== ei[i] || instr_done !== 1'b0)
                $display("FAIL illegal[%0d] got st=%0d ill=%b done=%b exp st=%0d ill=%b done=0",
                         i, state, illegal, instr_done, es[i], ei[i]);
            else passed++;
            @(posedge clk); #1;
        end
        total++;
        if (state !== 4'd0 || illegal !== 1'b1 || instr_count !== 32'd6)
            $display("FAIL illegal_end got st=%0d ill=%b cnt=%0d exp st=0 ill=1 cnt=6", state, illegal, instr_count);
        else passed++;
    endtask

    task automatic test_reset_mid();
        instruction = 32'h8C410001;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
        end
        mem_ready = 1'b0;
        #1;
        total++;
        if (state !== 4'd3 || MemRead !== 1'b1)
            $display("FAIL rmid_pre got st=%0d mr=%b exp st=3 mr=1", state, MemRead);
        else passed++;
        rst = 1'b1;
        #1;
        total++;
        if (ctl() !== 15'b00000000000_0010) $display("FAIL rmid_ctl got %b exp %b", ctl(), 15'b00000000000_0010);
        else passed++;
        @(posedge clk); #1;
        total++;
        if (state !== 4'd0 || instr_count !== 32'd0 || ctl() !== 15'b00000000000_0010)
            $display("FAIL rmid_post got st=%0d cnt=%0d ctl=%b exp st=0 cnt=0 ctl=%b",
                     state, instr_count, ctl(), 15'b00000000000_0010);
        else passed++;
        rst = 1'b0;
        mem_ready = 1'b1;
        test_lw(32'd1);
    endtask

    initial begin
        test_reset();
        test_lw(32'd1);
        test_sw_wait();
        test_rtype();
        test_andi_beq();
        test_illegal();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/mips_multicycle_control.md
Name: mips_multicycle_control

Overview:
- Multi-cycle main control FSM sitting directly upstream of the load/store + R/I-type datapath.
- Replaces bench-driven control: produces RegWrite, MemRead, MemWrite, MemtoReg, ALUSrc, RegDst and ALU_OP from the fetched instruction, plus IR/PC write enables.
- Handshakes with data memory through mem_ready.
- Reports instruction completion, illegal instructions, and a retired-instruction count.

Parameters:
- COUNT_W, 32, width of the retired-instruction counter instr_count.

Ports:
- clk  input  1  system clock, all state updates on posedge
- rst  input  1  reset, synchronous, active-high
- instruction  input  32  current instruction word from the instruction register / fetch stage
- zero_flag  input  1  ALU zero flag, used for beq
- mem_ready  input  1  data memory has completed the current read/write this cycle
- IRWrite  output  1  load instruction register
- PCWrite  output  1  unconditional PC update (PC+4)
- PCWriteCond  output  1  PC update if zero_flag (branch)
- RegWrite  output  1  register file write enable
- MemRead  output  1  data memory read enable
- MemWrite  output  1  data memory write enable
- MemtoReg  output  1  1 = writeback from memory, 0 = from ALU
- ALUSrc  output  1  1 = sign-extended immediate, 0 = register rt
- RegDst  output  1  1 = rd [15:11], 0 = rt [20:16]
- ALU_OP  output  4  0010 add, 0110 sub, 0000 and, 0001 or, 0111 slt
- instr_done  output  1  one-cycle pulse on the last cycle of each legal instruction
- illegal  output  1  one-cycle registered pulse on an unsupported opcode/funct
- branch_taken  output  1  PCWriteCond & zero_flag
- state  output  4  current FSM state, for debug
- instr_count  output  COUNT_W  count of completed legal instructions

Behaviour:
- Reset and outputs:
  - Synchronous reset: state <= FETCH, instr_count <= 0, illegal <= 0, op/funct latches <= 0.
  - While rst is high, all control outputs are forced to 0 and ALU_OP to 0010.
  - Reset mid-instruction aborts it, with no count increment.
  - Control outputs are Moore-decoded from state and the latched op_q/funct_q.
  - Unlisted outputs are 0; default ALU_OP is 0010.
- State encoding:
  - FETCH=0, DECODE=1, MEM_ADDR=2, MEM_READ=3, MEM_WB=4, MEM_WRITE=5, R_EXEC=6, R_WB=7, I_EXEC=8, I_WB=9, BRANCH=10.
- State actions and transitions:
  - FETCH: IRWrite=1, PCWrite=1; goes to DECODE.
  - DECODE:
    - Latches op_q=instruction[31:26] and funct_q=instruction[5:0].
    - 100011 lw and 101011 sw go to MEM_ADDR; 000000 goes to R_EXEC; 001000 addi, 001100 andi and 001101 ori go to I_EXEC; 000100 beq goes to BRANCH.
    - Any other opcode, or R-type funct not in {100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt}, goes to FETCH with illegal=1 next cycle and no count.
  - MEM_ADDR: ALUSrc=1; lw goes to MEM_READ, sw goes to MEM_WRITE.
  - MEM_READ: ALUSrc=1, MemRead=1; holds while mem_ready=0, goes to MEM_WB when 1.
  - MEM_WB: ALUSrc=1, MemRead=1, MemtoReg=1, RegWrite=1, RegDst=0, instr_done=1; goes to FETCH.
  - MEM_WRITE: ALUSrc=1, MemWrite=1; holds while mem_ready=0. When 1: instr_done=1, goes to FETCH.
  - R_EXEC: ALUSrc=0, ALU_OP by funct (add 0010, sub 0110, and 0000, or 0001, slt 0111); goes to R_WB.
  - R_WB: same ALU_OP plus RegDst=1, RegWrite=1, instr_done=1; goes to FETCH.
  - I_EXEC: ALUSrc=1, ALU_OP by opcode (addi 0010, andi 0000, ori 0001); goes to I_WB.
  - I_WB: same plus RegDst=0, RegWrite=1, instr_done=1; goes to FETCH.
  - BRANCH: ALUSrc=0, ALU_OP=0110, PCWriteCond=1, instr_done=1; goes to FETCH.
- Latency, with mem_ready=1: lw 5 cycles, sw 4, R-type 4, I-type 4, beq 3, illegal 2.
  - Each cycle of mem_ready=0 in MEM_READ/MEM_WRITE adds one cycle.
- Timing rules:
  - instruction changes after DECODE have no effect; op_q/funct_q are used.
  - instr_count increments on the edge leaving any cycle with instr_done=1 and wraps at 2^COUNT_W-1 to 0.
  - mem_ready outside MEM_READ/MEM_WRITE is ignored.

Test Plan:
- lw R1,1(R2) (0x8C410001), mem_ready=1 -> state 0,1,2,3,4,0.
  - RegWrite=1 and MemtoReg=1 only in state 4; instr_done one pulse; instr_count 0->1.
- sw R5,2(R5) (0xACA50002), mem_ready low for 3 cycles in state 5 -> MemWrite held 4 cycles.
  - RegWrite never 1; instr_done on the mem_ready cycle; total 7 cycles.
- add R16,R0,R1 (0x00018020), then sub R21,R9,R8 (0x0128A822):
  - add -> ALU_OP=0010 in states 6,7; RegDst=1, RegWrite=1 in state 7.
  - sub -> ALU_OP=0110 in states 6,7.
- andi R22,R6,0 (0x30D60000), then beq (0x10000003) with zero_flag=1:
  - andi -> ALU_OP=0000, ALUSrc=1, RegDst=0 in states 8,9.
  - beq -> state 10 with PCWriteCond=1, branch_taken=1, ALU_OP=0110.
- Illegal opcode 0xFC000000, and R-type funct 0x3F (0x0000003F) -> FETCH after DECODE, illegal pulse 1 cycle, instr_count unchanged.
- rst asserted while in MEM_READ -> next cycle state=0, all control outputs 0 while rst high, instr_count=0; a normal lw completes after release.
